// File: rtl/credit_tx_queue.sv
// Credit-gated transmit queue: buffers producer words in a FIFO and forwards
// them onto the link only while credits remain; yumi pulses return credits.
module credit_tx_queue #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CREDIT_WIDTH = 3,
  parameter int unsigned INIT_CREDITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      link_valid,
  output logic [DATA_WIDTH-1:0]     link_data,
  input  logic                      link_yumi,
  output logic [CREDIT_WIDTH-1:0]   credits,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      credit_err
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned MAX_CRED = (1 << CREDIT_WIDTH) - 1;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CREDIT_WIDTH-1:0] cred_q, cred_d;
  logic                    err_q, err_d;
  logic                    push, pop;

  // Ready/valid are derived from registered state only, so there is no in->link path.
  assign in_ready   = !rst && (cnt_q != CNT_W'(DEPTH));
  assign link_valid = !rst && (cnt_q != '0) && (cred_q != '0);
  assign link_data  = link_valid ? mem_q[rd_ptr_q] : '0;
  assign credits    = cred_q;
  assign fifo_count = cnt_q;
  assign credit_err = err_q;

  assign push = in_valid && in_ready;
  assign pop  = link_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    cred_d   = cred_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);

    // A yumi arriving at max credits saturates and latches the error flag.
    if (pop && !link_yumi) begin
      cred_d = cred_q - CREDIT_WIDTH'(1);
    end else if (!pop && link_yumi) begin
      if (cred_q == CREDIT_WIDTH'(MAX_CRED)) err_d = 1'b1;
      else                                   cred_d = cred_q + CREDIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= CREDIT_WIDTH'(INIT_CREDITS);
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
